switch_select_debounce: RTL and testbench

Input conditioning stage sitting directly upstream of the selective-blink demux. It synchronises and debounces the two raw board switches.
- The debounced switch levels drive the demux select inputs in place of the raw pins.
- It also provides a packed 2-bit select, a settled flag and a one-cycle change strobe for later mode logic.
- One clock domain (25 MHz board clock). Reset is synchronous and active-low.

---
 rtl/switch_pkg.sv | 14 +
 rtl/debounce_filter.sv | 60 ++++++
 rtl/switch_select_debounce.sv | 83 ++++++++
 tb/tb_switch_select_debounce.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// ============================================================================
// switch_pkg : shared constants for the switch conditioning stage
// Rev 1.0
// ============================================================================
`default_nettype none

package switch_pkg;

  localparam int DEBOUNCE_10MS_25MHZ = 250000;
  localparam int SELECT_W            = 2;

endpackage : switch_pkg

`default_nettype wire

// File: rtl/debounce_filter.sv
// ============================================================================
// debounce_filter : 2-flop synchroniser followed by a stable-count debouncer
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_filter
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_10MS_25MHZ
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Raw,
  output logic o_State
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             state_q;
  logic             state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Any sample matching the accepted level restarts qualification from zero.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (sync2_q == state_q) begin
      count_d = '0;
    end else if (count_q == CNT_MAX) begin
      state_d = sync2_q;
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= i_Raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign o_State = state_q;

endmodule : debounce_filter

`default_nettype wire

// File: rtl/switch_select_debounce.sv
// ============================================================================
// switch_select_debounce : debounced switch pair, packed select, settle flag
//                          and change strobe for the selective-blink demux
// Rev 1.0
// ============================================================================
`default_nettype none

module switch_select_debounce
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_10MS_25MHZ
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Switch_1,
  input  logic                i_Switch_2,
  output logic                o_Switch_1,
  output logic                o_Switch_2,
  output logic [SELECT_W-1:0] o_Select,
  output logic                o_Select_Valid,
  output logic                o_Change_Pulse
);

  localparam int            SETTLE_W   = $clog2(DEBOUNCE_LIMIT + 3);
  localparam logic [SETTLE_W-1:0] SETTLE_SAT = SETTLE_W'(DEBOUNCE_LIMIT + 2);

  logic [SELECT_W-1:0] w_raw;
  logic [SELECT_W-1:0] w_state;

  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] settle_d;
  logic                valid_q;
  logic                valid_prev_q;
  logic [SELECT_W-1:0] sel_prev_q;
  logic                pulse_q;

  assign w_raw = {i_Switch_2, i_Switch_1};

  for (genvar g = 0; g < SELECT_W; g++) begin : g_switch
    debounce_filter #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
    ) u_filter (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Raw   (w_raw[g]),
      .o_State (w_state[g])
    );
  end

  always_comb begin
    settle_d = settle_q;
    if (settle_q != SETTLE_SAT) begin
      settle_d = settle_q + 1'b1;
    end
  end

  // The strobe is gated by validity as it stood before the select moved, so a
  // level captured on the same edge that valid rises never produces a pulse.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      settle_q     <= '0;
      valid_q      <= 1'b0;
      valid_prev_q <= 1'b0;
      sel_prev_q   <= '0;
      pulse_q      <= 1'b0;
    end else begin
      settle_q     <= settle_d;
      valid_q      <= (settle_d == SETTLE_SAT);
      valid_prev_q <= valid_q;
      sel_prev_q   <= w_state;
      pulse_q      <= (w_state != sel_prev_q) && valid_prev_q;
    end
  end

  assign o_Switch_1     = w_state[0];
  assign o_Switch_2     = w_state[1];
  assign o_Select       = w_state;
  assign o_Select_Valid = valid_q;
  assign o_Change_Pulse = pulse_q;

endmodule : switch_select_debounce

`default_nettype wire

// File: tb/tb_switch_select_debounce.sv
// ============================================================================
// tb_switch_select_debounce : directed self-checking bench, limits 4 and 2
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_switch_select_debounce;

  logic       clk;
  logic       rst_l;
  logic       sw1;
  logic       sw2;

  logic       a_sw1, a_sw2, a_valid, a_pulse;
  logic [1:0] a_sel;
  logic       b_sw1, b_sw2, b_valid, b_pulse;
  logic [1:0] b_sel;

  int errors = 0;
  int checks = 0;

  switch_select_debounce #(.DEBOUNCE_LIMIT(4)) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_l),
    .i_Switch_1     (sw1),
    .i_Switch_2     (sw2),
    .o_Switch_1     (a_sw1),
    .o_Switch_2     (a_sw2),
    .o_Select       (a_sel),
    .o_Select_Valid (a_valid),
    .o_Change_Pulse (a_pulse)
  );

  switch_select_debounce #(.DEBOUNCE_LIMIT(2)) dut2 (
    .i_Clk          (clk),
    .i_Rst_L        (rst_l),
    .i_Switch_1     (sw1),
    .i_Switch_2     (sw2),
    .o_Switch_1     (b_sw1),
    .o_Switch_2     (b_sw2),
    .o_Select       (b_sel),
    .o_Select_Valid (b_valid),
    .o_Change_Pulse (b_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {sw2, sw1, select[1:0], valid, pulse}
  function automatic logic [5:0] pk(input logic [1:0] sel, input logic v, input logic p);
    return {sel, sel, v, p};
  endfunction

  task automatic chk(input string tag, input int e, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] obs_a;
  logic [5:0] obs_b;
  always_comb obs_a = {a_sw2, a_sw1, a_sel, a_valid, a_pulse};
  always_comb obs_b = {b_sw2, b_sw1, b_sel, b_valid, b_pulse};

  initial begin
    rst_l = 1'b0;
    sw1   = 1'b1;
    sw2   = 1'b1;

    // Reset held with both switches high
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("reset_a", e, obs_a, 6'b0);
      chk("reset_b", e, obs_b, 6'b0);
    end

    // Held through reset: level appears with valid, no pulse
    rst_l = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("held_a", e, obs_a, pk((e >= 6) ? 2'b11 : 2'b00, e >= 6, 1'b0));
      chk("held_b", e, obs_b, pk((e >= 4) ? 2'b11 : 2'b00, e >= 4, 1'b0));
    end

    // Re-reset with switches low and wait for valid
    rst_l = 1'b0;
    sw1   = 1'b0;
    sw2   = 1'b0;
    tick();
    tick();
    chk("rereset", 0, obs_a, 6'b0);
    rst_l = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("settle", e, obs_a, pk(2'b00, e >= 6, 1'b0));
    end

    // Clean press on switch 1
    for (int e = 0; e <= 8; e++) begin
      sw1 = 1'b1;
      tick();
      chk("press", e, obs_a, pk((e >= 5) ? 2'b01 : 2'b00, 1'b1, e == 6));
    end

    sw1 = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    chk("release1", 0, obs_a, pk(2'b00, 1'b1, 1'b0));

    // Bounce on switch 2: high 3, low 1, then held high
    for (int e = 0; e <= 11; e++) begin
      sw2 = (e == 3) ? 1'b0 : 1'b1;
      tick();
      chk("bounce", e, obs_a, pk((e >= 9) ? 2'b10 : 2'b00, 1'b1, e == 10));
    end

    sw2 = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    chk("release2", 0, obs_a, pk(2'b00, 1'b1, 1'b0));

    // Simultaneous rise: single select step, single pulse
    for (int e = 0; e <= 8; e++) begin
      sw1 = 1'b1;
      sw2 = 1'b1;
      tick();
      chk("simul", e, obs_a, pk((e >= 5) ? 2'b11 : 2'b00, 1'b1, e == 6));
    end

    // Reset while the filter counters sit at 2
    for (int e = 0; e <= 3; e++) begin
      sw1 = 1'b0;
      sw2 = 1'b0;
      tick();
      chk("midqual", e, obs_a, pk(2'b11, 1'b1, 1'b0));
    end
    rst_l = 1'b0;
    tick();
    chk("midrst0", 4, obs_a, 6'b0);
    tick();
    chk("midrst1", 5, obs_a, 6'b0);
    rst_l = 1'b1;
    sw2   = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk("restart", e, obs_a, pk((e >= 6) ? 2'b10 : 2'b00, e >= 6, 1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_switch_select_debounce

`default_nettype wire
